regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, write data width in bits.
REQ-002 Parameter: ADDR_W, 5, register address width in bits (32 registers).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req0_valid  in  1  requester 0 write request.
REQ-006 req0_ready  out  1  requester 0 accepted this cycle.
REQ-007 req0_addr  in  ADDR_W  requester 0 destination register.
REQ-008 req0_data  in  DATA_W  requester 0 write data.
REQ-009 req1_valid / req1_ready / req1_addr / req1_data: same as REQ-005 to REQ-008, for requester 1.
REQ-010 we  out  1  register-file write enable.
REQ-011 wa  out  ADDR_W  register-file write address.
REQ-012 wd  out  DATA_W  register-file write data.
REQ-013 pending  out  2**ADDR_W  per-register "write not yet committed" mask.
REQ-014 last_grant  out  1  index of the most recently granted requester.

Function
REQ-015 Transfer: occurs on reqN when reqN_valid and reqN_ready are both 1 on a rising edge.
REQ-016 Ready generation:
- reqN_ready is combinational from valid, the priority pointer and rst.
- At most one of req0_ready and req1_ready is 1 in any cycle.
REQ-017 Single requester valid: that requester gets ready=1 in the same cycle.
REQ-018 Both requesters valid: the requester selected by the priority pointer gets ready.
REQ-019 Priority pointer:
- Reset value selects req0.
- After a transfer from reqN, the pointer selects the other requester.
- With no transfer, the pointer holds.
REQ-020 Requester rule:
- Once valid is asserted, it stays at 1 with addr and data stable until the transfer.
- The block does not check this rule.
REQ-021 Write latency:
- One cycle. The cycle after a transfer: we=1, wa and wd equal the transferred addr and data, last_grant equals N.
- Cycles with no preceding transfer: we=0; wa, wd and last_grant hold their values.
REQ-022 Throughput: one write per cycle. Back-to-back transfers produce we=1 on consecutive cycles.
REQ-023 pending[k] is combinational and equals 1 when either of these holds:
- any reqN_valid=1 with reqN_addr=k and no transfer this cycle; or
- we=1 with wa=k.
REQ-024 Same address on both requesters: both writes commit in grant order on successive cycles; the later grant's data is the final register value.
REQ-025 Starvation bound: a continuously valid requester is granted within 2 cycles.

Reset
REQ-026 While rst=1: req0_ready=0, req1_ready=0, and no transfer occurs.
REQ-027 Reset values of registered outputs: we=0, wa=0, wd=0, last_grant=1; the priority pointer selects req0.
REQ-028 Reset mid-operation: a transfer registered in the cycle before rst rises is dropped, and we is 0 in every cycle with rst=1.
REQ-029 First cycle after rst falls: normal arbitration per REQ-016 to REQ-019.
REQ-030 pending during reset: reflects only the valid inputs (per REQ-023, with we=0).

Configuration
REQ-031 Macro ZERO_REG_PROTECT_EN, defined: transfers to address 0 complete normally (ready and pointer update as usual), but:
- we stays 0 in the following cycle;
- wa, wd and last_grant still update;
- pending[0] is always 0.
REQ-032 Macro ZERO_REG_PROTECT_EN, undefined: address 0 is treated like every other address.

Verification
REQ-033 Reset behaviour: assert rst for 2 cycles with both valid=1 -> both ready=0, we=0, wa=0, wd=0; in the first cycle after release, req0_ready=1.
REQ-034 Contention: req0 (addr 3, 0xAAAA0000) and req1 (addr 3, 0x5555FFFF) held valid -> req0 granted, then req1; we=1 on two consecutive cycles with wa=3, wd=0xAAAA0000 then 0x5555FFFF; pending[3]=1 until the cycle after the second commit.
REQ-035 Fairness: both requesters valid for 6 cycles -> grants alternate 0,1,0,1,0,1; last_grant follows one cycle later.
REQ-036 Single requester streaming: req1 only, addrs 1..4 with data 0x11..0x44 -> ready=1 every cycle; we=1 for 4 consecutive cycles with matching wa/wd.
REQ-037 Reset mid-flight: transfer of addr 7, 0xDEADBEEF in cycle T and rst=1 in cycle T+1 -> we=0 in T+1 and pending[7]=0.
REQ-038 Zero-register handling: req0 to addr 0 with data 0x12345678 -> with ZERO_REG_PROTECT_EN, req0_ready=1, then we=0 and pending[0]=0; without the macro, we=1, wa=0, wd=0x12345678.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter for a register file with a one-cycle write pipeline.
// Optional macro ZERO_REG_PROTECT_EN suppresses commits to register 0.
module regfile_write_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic [ADDR_W-1:0]        req0_addr,
   input  logic [DATA_W-1:0]        req0_data,
   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic [ADDR_W-1:0]        req1_addr,
   input  logic [DATA_W-1:0]        req1_data,
   output logic                     we,
   output logic [ADDR_W-1:0]        wa,
   output logic [DATA_W-1:0]        wd,
   output logic [(2**ADDR_W)-1:0]   pending,
   output logic                     last_grant
);

   localparam int unsigned NREG = 2 ** ADDR_W;

   typedef enum logic {
      PRI_REQ0 = 1'b0,
      PRI_REQ1 = 1'b1
   } pri_t;

   pri_t              pri_q;
   pri_t              pri_d;
   logic              xfer0;
   logic              xfer1;
   logic              xfer;
   logic              xfer_id;
   logic [ADDR_W-1:0] xfer_addr;
   logic [DATA_W-1:0] xfer_data;
   logic              commit_c;
   logic              we_q;

   // Grant selection and priority pointer next state
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      pri_d      = pri_q;
      if (!rst) begin
         if (req0_valid && (!req1_valid || pri_q == PRI_REQ0)) begin
            req0_ready = 1'b1;
         end else if (req1_valid) begin
            req1_ready = 1'b1;
         end
      end
      xfer0 = req0_valid && req0_ready;
      xfer1 = req1_valid && req1_ready;
      if (xfer0) begin
         pri_d = PRI_REQ1;
      end else if (xfer1) begin
         pri_d = PRI_REQ0;
      end
   end

   assign xfer      = xfer0 || xfer1;
   assign xfer_id   = xfer1;
   assign xfer_addr = xfer1 ? req1_addr : req0_addr;
   assign xfer_data = xfer1 ? req1_data : req0_data;

`ifdef ZERO_REG_PROTECT_EN
   assign commit_c = xfer && (xfer_addr != '0);
`else
   assign commit_c = xfer;
`endif

   // Pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         pri_q <= PRI_REQ0;
      end else begin
         pri_q <= pri_d;
      end
   end

   // Write pipeline stage; wa/wd/last_grant hold when nothing transfers
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q       <= 1'b0;
         wa         <= '0;
         wd         <= '0;
         last_grant <= 1'b1;
      end else begin
         we_q <= commit_c;
         if (xfer) begin
            wa         <= xfer_addr;
            wd         <= xfer_data;
            last_grant <= xfer_id;
         end
      end
   end

   // A write launched just before reset must not reach the register file
   assign we = we_q && !rst;

   // Outstanding writes: waiting requests plus the one committing now
   always_comb begin
      pending = '0;
      for (int unsigned k = 0; k < NREG; k++) begin
         if ((req0_valid && !xfer0 && req0_addr == ADDR_W'(k)) ||
             (req1_valid && !xfer1 && req1_addr == ADDR_W'(k)) ||
             (we && wa == ADDR_W'(k))) begin
            pending[k] = 1'b1;
         end
      end
`ifdef ZERO_REG_PROTECT_EN
      pending[0] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table plus scoreboard
// of registered outputs expected one cycle after each driven cycle.
module tb_regfile_write_arbiter;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
`ifdef ZERO_REG_PROTECT_EN
   localparam bit ZP = 1'b1;
`else
   localparam bit ZP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_valid, req0_ready, req1_valid, req1_ready;
   logic [ADDR_W-1:0] req0_addr, req1_addr, wa;
   logic [DATA_W-1:0] req0_data, req1_data, wd;
   logic              we, last_grant;
   logic [31:0]       pending;

   regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_addr(req1_addr), .req1_data(req1_data),
      .we(we), .wa(wa), .wd(wd), .pending(pending), .last_grant(last_grant)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        v0;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic        v1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic        r0;
      logic        r1;
      logic [4:0]  pa;
      logic        pv;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        lg;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        lg;
   } regs_t;

   regs_t sb_q[$];
   vec_t  tbl[16];
   int    n_checks = 0;
   int    n_fail   = 0;

   function automatic vec_t mk(input logic r, input logic v0, input logic [4:0] a0,
                               input logic [31:0] d0, input logic v1, input logic [4:0] a1,
                               input logic [31:0] d1, input logic r0, input logic r1,
                               input logic [4:0] pa, input logic pv, input logic e_we,
                               input logic [4:0] e_wa, input logic [31:0] e_wd,
                               input logic e_lg);
      vec_t v;
      v.rst = r;  v.v0 = v0; v.a0 = a0; v.d0 = d0;
      v.v1 = v1;  v.a1 = a1; v.d1 = d1;
      v.r0 = r0;  v.r1 = r1; v.pa = pa; v.pv = pv;
      v.we = e_we; v.wa = e_wa; v.wd = e_wd; v.lg = e_lg;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle, check combinational outputs, then check registered ones
   task automatic step(input vec_t v, input string tag);
      regs_t e;
      @(negedge clk);
      rst        = v.rst;
      req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
      req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
      #1;
      chk({tag, ".req0_ready"}, 32'(req0_ready), 32'(v.r0));
      chk({tag, ".req1_ready"}, 32'(req1_ready), 32'(v.r1));
      chk({tag, ".pending"}, 32'(pending[v.pa]), 32'(v.pv));
      e.we = v.we; e.wa = v.wa; e.wd = v.wd; e.lg = v.lg;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, ".we"}, 32'(we), 32'(e.we));
         chk({tag, ".wa"}, 32'(wa), 32'(e.wa));
         chk({tag, ".wd"}, wd, e.wd);
         chk({tag, ".last_grant"}, 32'(last_grant), 32'(e.lg));
      end
   endtask

   localparam logic [31:0] DA = 32'hAAAA_0000;
   localparam logic [31:0] DB = 32'h5555_FFFF;

   initial begin
      logic [4:0]  a0c, a1c, ga;
      logic [31:0] gd;
      logic        g;

      rst = 1'b1;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

      // Reset hold, contention on addr 3, req1 streaming, mixed priority
      tbl[0]  = mk(1, 1, 5'd3, DA, 1, 5'd3, DB, 0, 0, 5'd3, 1, 0, 5'd0, 32'h0, 1);
      tbl[1]  = mk(1, 1, 5'd3, DA, 1, 5'd3, DB, 0, 0, 5'd3, 1, 0, 5'd0, 32'h0, 1);
      tbl[2]  = mk(0, 1, 5'd3, DA, 1, 5'd3, DB, 1, 0, 5'd3, 1, 1, 5'd3, DA, 0);
      tbl[3]  = mk(0, 0, 5'd0, 0,  1, 5'd3, DB, 0, 1, 5'd3, 1, 1, 5'd3, DB, 1);
      tbl[4]  = mk(0, 0, 5'd0, 0,  0, 5'd0, 0,  0, 0, 5'd3, 1, 0, 5'd3, DB, 1);
      tbl[5]  = mk(0, 0, 5'd0, 0,  0, 5'd0, 0,  0, 0, 5'd3, 0, 0, 5'd3, DB, 1);
      tbl[6]  = mk(0, 0, 5'd0, 0,  1, 5'd1, 32'h11, 0, 1, 5'd1, 0, 1, 5'd1, 32'h11, 1);
      tbl[7]  = mk(0, 0, 5'd0, 0,  1, 5'd2, 32'h22, 0, 1, 5'd1, 1, 1, 5'd2, 32'h22, 1);
      tbl[8]  = mk(0, 0, 5'd0, 0,  1, 5'd3, 32'h33, 0, 1, 5'd2, 1, 1, 5'd3, 32'h33, 1);
      tbl[9]  = mk(0, 0, 5'd0, 0,  1, 5'd4, 32'h44, 0, 1, 5'd4, 0, 1, 5'd4, 32'h44, 1);
      tbl[10] = mk(0, 0, 5'd0, 0,  0, 5'd0, 0,  0, 0, 5'd4, 1, 0, 5'd4, 32'h44, 1);
      tbl[11] = mk(0, 1, 5'd9, 32'h99, 0, 5'd0, 0, 1, 0, 5'd9, 0, 1, 5'd9, 32'h99, 0);
      tbl[12] = mk(0, 1, 5'd10, 32'hA0, 1, 5'd11, 32'hB1, 0, 1, 5'd10, 1, 1, 5'd11, 32'hB1, 1);
      tbl[13] = mk(0, 1, 5'd10, 32'hA0, 1, 5'd12, 32'hC2, 1, 0, 5'd12, 1, 1, 5'd10, 32'hA0, 0);
      tbl[14] = mk(0, 0, 5'd0, 0,  1, 5'd12, 32'hC2, 0, 1, 5'd10, 1, 1, 5'd12, 32'hC2, 1);
      tbl[15] = mk(0, 0, 5'd0, 0,  0, 5'd0, 0,  0, 0, 5'd12, 1, 0, 5'd12, 32'hC2, 1);

      for (int i = 0; i < 16; i++) begin
         step(tbl[i], $sformatf("v%0d", i));
      end

      // Fairness: both valid for 6 cycles, grants alternate starting at req0
      a0c = 5'd16;
      a1c = 5'd20;
      for (int i = 0; i < 6; i++) begin
         g  = 1'(i % 2);
         ga = g ? a1c : a0c;
         gd = g ? (32'hE000_0000 | 32'(a1c)) : (32'hF000_0000 | 32'(a0c));
         step(mk(0, 1, a0c, 32'hF000_0000 | 32'(a0c), 1, a1c, 32'hE000_0000 | 32'(a1c),
                 !g, g, g ? a0c : a1c, 1, 1, ga, gd, g),
              $sformatf("fair%0d", i));
         if (g) a1c = a1c + 5'd1;
         else   a0c = a0c + 5'd1;
      end
      step(mk(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'd22, 1, 0, 5'd22, 32'hE000_0016, 1), "fair_idle");

      // Reset arriving right after a transfer drops the commit
      step(mk(0, 1, 5'd7, 32'hDEAD_BEEF, 0, 5'd0, 0, 1, 0, 5'd7, 0, 1, 5'd7, 32'hDEAD_BEEF, 0),
           "rmf_xfer");
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b0;
      #1;
      chk("rmf.we_in_reset", 32'(we), 32'd0);
      chk("rmf.pending7", 32'(pending[7]), 32'd0);
      chk("rmf.req0_ready", 32'(req0_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("rmf.we_after", 32'(we), 32'd0);
      chk("rmf.wa_after", 32'(wa), 32'd0);
      chk("rmf.wd_after", wd, 32'd0);
      chk("rmf.lg_after", 32'(last_grant), 32'd1);
      step(mk(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'd7, 0, 0, 5'd0, 32'h0, 1), "rmf_release");

      // Register 0 write
      step(mk(0, 1, 5'd0, 32'h1234_5678, 0, 5'd0, 0, 1, 0, 5'd0, 0,
              !ZP, 5'd0, 32'h1234_5678, 0), "zero_xfer");
      step(mk(0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'd0, !ZP,
              0, 5'd0, 32'h1234_5678, 0), "zero_idle");

      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
